noc_traffic_endpoint: RTL

Parametrised successor of the per-node processing unit. It sits between one NoC router port and the testbench/command side and has two paths:
- TX: accepts a burst command (destination, length), requests the bus master, and once granted emits a numbered flit burst with a last-flit marker and router backpressure.
- RX: checks incoming bursts for sequence order, counts completed packets and latches errors.

---
 rtl/noc_traffic_endpoint.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/noc_traffic_endpoint.sv
// noc_traffic_endpoint: one NoC router port endpoint.
// TX path turns a (dest, len) command into a bus request followed by a
// numbered flit burst {last, seq}. RX path checks incoming sequence numbers,
// counts completed packets and keeps a sticky error flag.
module noc_traffic_endpoint #(
  parameter int DATA_W    = 8,
  parameter int NUM_NODES = 4,
  parameter int NODE_ID   = 0,
  parameter int CNT_W     = 16,
  localparam int DEST_W   = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DEST_W-1:0] cmd_dest,
  input  logic [DATA_W-1:0] cmd_len,
  // bus master handshake
  output logic              req,
  output logic [DEST_W-1:0] req_dest,
  input  logic              grant,
  // router TX
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W:0]   tx_flit,
  output logic              done,
  // router RX
  input  logic              rx_valid,
  input  logic [DATA_W:0]   rx_flit,
  output logic [CNT_W-1:0]  rx_pkt_count,
  output logic              rx_err,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DEST_W-1:0]   r_dest, w_dest_nxt;
  logic [DATA_W-1:0]   r_len, w_len_nxt;
  logic [DATA_W-1:0]   r_seq, w_seq_nxt;
  logic                r_req, w_req_nxt;
  logic [DEST_W-1:0]   r_req_dest, w_req_dest_nxt;
  logic                r_tx_valid, w_tx_valid_nxt;
  logic [DATA_W:0]     r_tx_flit, w_tx_flit_nxt;
  logic                r_done, w_done_nxt;
  logic                r_busy, w_busy_nxt;
  logic [DATA_W-1:0]   w_seq_inc;

  logic [DATA_W-1:0]   r_rx_exp;
  logic [CNT_W-1:0]    r_rx_cnt;
  logic                r_rx_err;
  logic [DATA_W-1:0]   w_rx_payload;
  logic                w_rx_last;

  // Only combinational output: a command is taken whenever the FSM is idle,
  // which lets a new command land in the same cycle done is high.
  assign cmd_ready = (r_state == S_IDLE);

  assign w_seq_inc = r_seq + DATA_W'(1);

  // TX next-state and next-output computation; all outputs are registered.
  always_comb begin
    w_state_nxt    = r_state;
    w_dest_nxt     = r_dest;
    w_len_nxt      = r_len;
    w_seq_nxt      = r_seq;
    w_req_nxt      = r_req;
    w_req_dest_nxt = r_req_dest;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_flit_nxt  = r_tx_flit;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // zero-length commands are consumed without any effect
        if (cmd_valid && (cmd_len != '0)) begin
          w_dest_nxt     = cmd_dest;
          w_len_nxt      = cmd_len;
          w_req_nxt      = 1'b1;
          w_req_dest_nxt = cmd_dest;
          w_state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (grant) begin
          w_req_nxt      = 1'b0;
          w_tx_valid_nxt = 1'b1;
          w_seq_nxt      = DATA_W'(1);
          w_tx_flit_nxt  = {(r_len == DATA_W'(1)), DATA_W'(1)};
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        // grant is deliberately ignored here; only router backpressure matters
        if (tx_ready) begin
          if (r_seq == r_len) begin
            w_tx_valid_nxt = 1'b0;
            w_done_nxt     = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_seq_nxt     = w_seq_inc;
            w_tx_flit_nxt = {(w_seq_inc == r_len), w_seq_inc};
          end
        end
      end
      default: begin
        w_req_nxt      = 1'b0;
        w_tx_valid_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // TX state and registered outputs; reset aborts a burst with no done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dest     <= '0;
      r_len      <= '0;
      r_seq      <= '0;
      r_req      <= 1'b0;
      r_req_dest <= '0;
      r_tx_valid <= 1'b0;
      r_tx_flit  <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dest     <= w_dest_nxt;
      r_len      <= w_len_nxt;
      r_seq      <= w_seq_nxt;
      r_req      <= w_req_nxt;
      r_req_dest <= w_req_dest_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_flit  <= w_tx_flit_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign w_rx_payload = rx_flit[DATA_W-1:0];
  assign w_rx_last    = rx_flit[DATA_W];

  // RX sequence checker: resync after a mismatch, restart at 1 after a last flit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_exp <= DATA_W'(1);
      r_rx_cnt <= '0;
      r_rx_err <= 1'b0;
    end else if (rx_valid) begin
      if (w_rx_payload != r_rx_exp) begin
        r_rx_err <= 1'b1;
        r_rx_exp <= w_rx_payload + DATA_W'(1);
      end else begin
        r_rx_exp <= r_rx_exp + DATA_W'(1);
      end
      if (w_rx_last) begin
        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        r_rx_exp <= DATA_W'(1);
      end
    end
  end

  assign req          = r_req;
  assign req_dest     = r_req_dest;
  assign tx_valid     = r_tx_valid;
  assign tx_flit      = r_tx_flit;
  assign done         = r_done;
  assign busy         = r_busy;
  assign rx_pkt_count = r_rx_cnt;
  assign rx_err       = r_rx_err;

endmodule
